// File: rtl/shift_seq32.sv
`default_nettype none
// ============================================================================
// Module      : shift_seq32
// Description : Multi-cycle 32-bit shifter. Consumes the requested shift
//               amount (0-31) in steps of at most 3 positions per clock,
//               applying each step to a working register that is also the
//               result output. Supports LSL, LSR and ASR.
//               Optional build macro SHIFT_SEQ32_ROR_EN: when defined, op=11
//               is rotate-right; when undefined, op=11 behaves as LSR.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_seq32 #(
  parameter int STEP_BITS = 2  // per-cycle step width; only 2 is supported
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [4:0]  shamt,
  input  logic [31:0] d_in,
  output logic [31:0] d_out,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0] OP_LSL = 2'b00;
  localparam logic [1:0] OP_ASR = 2'b10;
`ifdef SHIFT_SEQ32_ROR_EN
  localparam logic [1:0] OP_ROR = 2'b11;
`endif

  // Largest distance one step may cover, widened to the counter width
  localparam logic [4:0] MAX_STEP = 5'((1 << STEP_BITS) - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t                 state;
  logic [4:0]             cnt;       // shift positions still to apply
  logic [1:0]             op_r;      // operation captured at the accepting edge
  logic [STEP_BITS-1:0]   step;      // positions applied on this edge
  logic                   last_step; // this edge consumes the remainder
  logic [31:0]            shifted;   // working register after this step

  // Step size is the remaining count, clamped to the per-cycle maximum
  always_comb begin
    last_step = (cnt <= MAX_STEP);
    step      = last_step ? cnt[STEP_BITS-1:0] : MAX_STEP[STEP_BITS-1:0];
  end

  // One combinational shift stage of 0..MAX_STEP positions
  always_comb begin
    shifted = d_out >> step;
    case (op_r)
      OP_LSL:  shifted = d_out << step;
      OP_ASR:  shifted = $signed(d_out) >>> step;
`ifdef SHIFT_SEQ32_ROR_EN
      // Bits leaving the bottom re-enter at the top; a zero step shifts the
      // left term out completely, leaving the value unchanged
      OP_ROR:  shifted = (d_out >> step) | (d_out << (32 - int'(step)));
`endif
      default: shifted = d_out >> step;  // LSR (and op=11 without rotate)
    endcase
  end

  // Sequencer: accept in IDLE, iterate steps in SHIFT, pulse done in DONE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      d_out <= 32'd0;
      cnt   <= 5'd0;
      op_r  <= 2'b00;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            d_out <= d_in;
            cnt   <= shamt;
            op_r  <= op;
            busy  <= 1'b1;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // step never exceeds cnt, so the counter cannot wrap
          d_out <= shifted;
          cnt   <= cnt - {{(5 - STEP_BITS){1'b0}}, step};
          if (last_step) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_shift_seq32.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_seq32
// Description : Self-checking bench for shift_seq32. Expected results are the
//               whole shift done in one go; expected latency is
//               max(1, ceil(shamt/3)) SHIFT cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_seq32;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [4:0]  shamt;
  logic [31:0] d_in;
  logic [31:0] d_out;
  logic        busy;
  logic        done;

  int n_checks;
  int n_errors;

  shift_seq32 #(.STEP_BITS(2)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .shamt (shamt),
    .d_in  (d_in),
    .d_out (d_out),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Whole-shift reference: result of shifting d by s in one operation
  function automatic logic [31:0] ref_shift(input logic [1:0] o, input logic [4:0] s,
                                            input logic [31:0] d);
    logic [31:0] r;
    logic [63:0] dd;
    case (o)
      2'b00: r = d << s;
      2'b10: r = $signed(d) >>> s;
`ifdef SHIFT_SEQ32_ROR_EN
      2'b11: begin
        dd = {d, d} >> s;
        r  = dd[31:0];
      end
`endif
      default: r = d >> s;
    endcase
    return r;
  endfunction

  function automatic int ref_cycles(input logic [4:0] s);
    return (s == 5'd0) ? 1 : (int'(s) + 2) / 3;
  endfunction

  // One complete request; junk=1 keeps start high with random operands
  // throughout SHIFT and DONE to prove they are ignored
  task automatic run_op(input logic [1:0] o, input logic [4:0] s,
                        input logic [31:0] d, input bit junk);
    logic [31:0] exp;
    int          n;
    exp = ref_shift(o, s, d);
    @(negedge clk);
    start = 1'b1; op = o; shamt = s; d_in = d;
    @(posedge clk); #1;
    check("busy_after_accept", busy, 1'b1);
    n = 0;
    while (!done && n < 40) begin
      start = junk;
      op    = 2'($urandom);
      shamt = 5'($urandom);
      d_in  = $urandom;
      @(posedge clk); #1;
      n++;
      if (!done) check("busy_in_shift", busy, 1'b1);
    end
    check("done_seen", done, 1'b1);
    check("latency", n, ref_cycles(s));
    check("result", d_out, exp);
    check("busy_on_done", busy, 1'b0);
    start = junk;
    d_in  = $urandom;
    @(posedge clk); #1;
    check("done_one_cycle", done, 1'b0);
    check("idle_not_busy", busy, 1'b0);
    check("idle_hold", d_out, exp);
    start = 1'b0;
  endtask

  initial begin
    bit seen_done;
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1; start = 1'b0; op = 2'b00; shamt = 5'd0; d_in = 32'd0;
    #2;
    check("rst_d_out", d_out, 32'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    @(negedge clk); reset = 1'b0;

    // Directed cases
    run_op(2'b01, 5'd31, 32'h8000_0000, 1'b0);  // long LSR
    run_op(2'b10, 5'd4,  32'h8000_0000, 1'b0);  // ASR sign fill
    run_op(2'b00, 5'd0,  32'h0000_0001, 1'b0);  // zero shift
    run_op(2'b00, 5'd5,  32'h0000_0001, 1'b0);  // back-to-back
    run_op(2'b01, 5'd9,  32'hFFFF_FFFF, 1'b1);  // start ignored while busy
    run_op(2'b11, 5'd8,  32'h1234_5678, 1'b0);  // rotate / LSR
    run_op(2'b00, 5'd3,  32'hA5A5_A5A5, 1'b0);  // single full step
    run_op(2'b10, 5'd31, 32'h7FFF_FFFF, 1'b0);  // ASR positive

    // Reset during SHIFT aborts asynchronously
    @(negedge clk);
    start = 1'b1; op = 2'b00; shamt = 5'd20; d_in = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    check("abort_d_out", d_out, 32'd0);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    @(negedge clk); reset = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done || busy) seen_done = 1'b1;
    end
    check("no_done_after_abort", seen_done, 1'b0);

    // Randomized requests
    for (int i = 0; i < 40; i++) begin
      run_op(2'($urandom), 5'($urandom), $urandom, 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
